fpu: RTL and testbench

Sequential 16-bit IEEE-754 half-precision arithmetic unit that loads its operands and operation serially over a shared 16-bit `data` bus. Each `start` pulse advances a load/execute sequence: operand A, operand B, opcode, then execute. It computes add, subtract, multiply or divide and reports completion on `ready` and exceptional results on `error`. It sits behind a simple controller that owns the bus and polls `ready`.

---
 rtl/fpu_if.sv | 12 +
 rtl/fpu.sv | 193 +++++++++++++++++++
 tb/tb_fpu.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_if.sv
// Shared load bus between the controller and the FPU: one data word plus a step strobe in,
// result/error/ready out. The controller owns data/start and polls ready; there is no other flow control.
interface fpu_if;
    logic [15:0] data;
    logic        start;
    logic        ready;
    logic        error;
    logic [15:0] result;

    modport master (output data, start, input ready, error, result);
    modport slave  (input data, start, output ready, error, result);
endinterface

// File: rtl/fpu.sv
// Serially loaded half-precision add/sub/mul/div; ready rises 3 cycles (div: 15) after the execute step.
// Steps arriving while busy are dropped; ready holds until the next accepted step.
module fpu (
    input  logic clk,
    input  logic rst,
    fpu_if.slave fpu_io
);
    typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC, BUSY, DONE} state_t;

    localparam logic [15:0] QNAN   = 16'h7E00;
    localparam logic [1:0]  OP_SUB = 2'd1;
    localparam logic [1:0]  OP_MUL = 2'd2;
    localparam logic [1:0]  OP_DIV = 2'd3;

    state_t      state_q;
    logic        start_q;
    logic [15:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [3:0]  cnt_q;
    logic [11:0] rem_q;
    logic [12:0] quo_q;
    logic        ready_q, error_q;
    logic [15:0] result_q;

    logic        step;
    logic [4:0]  ea, eb;
    logic        za, zb, sa, sb, special;
    logic [10:0] ma, mb;

    assign step    = fpu_io.start & ~start_q;
    assign ea      = a_q[14:10];
    assign eb      = b_q[14:10];
    assign za      = (ea == 5'd0);
    assign zb      = (eb == 5'd0);
    assign ma      = za ? 11'd0 : {1'b1, a_q[9:0]};
    assign mb      = zb ? 11'd0 : {1'b1, b_q[9:0]};
    assign sa      = a_q[15];
    assign sb      = b_q[15] ^ (op_q == OP_SUB);
    assign special = (ea == 5'd31) | (eb == 5'd31);

    // Add/sub: the lowest guard bit is sticky, so truncation matches the exact result.
    logic        a_big, eff_sub, sticky, s_big;
    logic [4:0]  e_big, shamt;
    logic [10:0] m_big, m_sml;
    logic [13:0] sml_ext, sml_aln, lost_mask;
    logic [14:0] sum, norm;
    logic [3:0]  lz;

    assign a_big     = {ea, ma} >= {eb, mb};
    assign e_big     = a_big ? ea : eb;
    assign s_big     = a_big ? sa : sb;
    assign shamt     = a_big ? (ea - eb) : (eb - ea);
    assign m_big     = a_big ? ma : mb;
    assign m_sml     = a_big ? mb : ma;
    assign eff_sub   = sa ^ sb;
    assign sml_ext   = {m_sml, 3'b000};
    assign lost_mask = ~(14'h3FFF << shamt);
    assign sticky    = |(sml_ext & lost_mask);
    assign sml_aln   = (sml_ext >> shamt) | {13'd0, sticky};
    assign sum       = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, sml_aln})
                               : ({1'b0, m_big, 3'b000} + {1'b0, sml_aln});

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (sum[i]) lz = 4'(14 - i);
        end
    end

    assign norm = sum << lz;

    logic [21:0] prod;
    assign prod = ma * mb;

    logic [11:0] rem_diff;
    logic        rem_ge;
    assign rem_ge   = rem_q >= {1'b0, mb};
    assign rem_diff = rem_q - {1'b0, mb};

    logic signed [6:0] r_exp;
    logic [9:0]        r_frac;
    logic              r_sign, r_zero, r_err;
    logic [15:0]       result_d;
    logic              error_d;

    always_comb begin
        r_exp  = 7'sd0;
        r_frac = 10'd0;
        r_sign = 1'b0;
        r_zero = 1'b0;
        r_err  = 1'b0;
        case (op_q)
            OP_MUL: begin
                r_sign = sa ^ sb;
                r_zero = za | zb;
                r_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15
                       + $signed({6'd0, prod[21]});
                r_frac = 10'(prod >> (prod[21] ? 11 : 10));
            end
            OP_DIV: begin
                r_sign = sa ^ sb;
                r_err  = zb;
                r_zero = za;
                r_exp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd14
                       + $signed({6'd0, quo_q[12]});
                r_frac = 10'(quo_q >> (quo_q[12] ? 2 : 1));
            end
            default: begin
                r_zero = (sum == 15'd0);
                r_sign = r_zero ? 1'b0 : s_big;
                r_exp  = $signed({2'b00, e_big}) + 7'sd1 - $signed({3'b000, lz});
                r_frac = 10'(norm >> 4);
            end
        endcase

        error_d  = 1'b0;
        result_d = {r_sign, r_exp[4:0], r_frac};
        if (special | r_err | (!r_zero && (r_exp > 7'sd30))) begin
            error_d  = 1'b1;
            result_d = QNAN;
        end else if (r_zero | (r_exp < 7'sd1)) begin
            result_d = {r_sign, 15'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD_A;
            start_q  <= 1'b0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            op_q     <= 2'd0;
            cnt_q    <= 4'd0;
            rem_q    <= 12'd0;
            quo_q    <= 13'd0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= 16'd0;
        end else begin
            start_q <= fpu_io.start;
            case (state_q)
                LOAD_A, DONE: begin
                    if (step) begin
                        a_q     <= fpu_io.data;
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (step) begin
                        b_q     <= fpu_io.data;
                        state_q <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (step) begin
                        op_q    <= fpu_io.data[1:0];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (step) begin
                        cnt_q   <= 4'd0;
                        rem_q   <= {1'b0, ma};
                        quo_q   <= 13'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // One restoring-division quotient bit per cycle for the first 13 busy cycles.
                    if ((op_q == OP_DIV) && (cnt_q < 4'd13)) begin
                        rem_q <= rem_ge ? (rem_diff << 1) : (rem_q << 1);
                        quo_q <= {quo_q[11:0], rem_ge};
                    end
                    if (cnt_q == ((op_q == OP_DIV) ? 4'd14 : 4'd2)) begin
                        ready_q  <= 1'b1;
                        error_q  <= error_d;
                        result_q <= result_d;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign fpu_io.ready  = ready_q;
    assign fpu_io.error  = error_q;
    assign fpu_io.result = result_q;
endmodule

// File: tb/tb_fpu.sv
// Scoreboard bench for the serial half-precision FPU: stimulus pushes expected results,
// a negedge monitor compares result, error and latency whenever ready rises.
module tb_fpu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_if bus ();
    fpu dut (.clk(clk), .rst(rst), .fpu_io(bus));

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
        int          cyc;
        int          id;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] res;
        logic        err;
    } vec_t;

    localparam int NDIR = 17;
    vec_t dir [NDIR] = '{
        '{16'h3C00, 16'h3C00, 2'd0, 16'h4000, 1'b0},
        '{16'h4200, 16'h3C00, 2'd1, 16'h4000, 1'b0},
        '{16'h4000, 16'h4200, 2'd2, 16'h4600, 1'b0},
        '{16'hC000, 16'h4000, 2'd2, 16'hC400, 1'b0},
        '{16'h4600, 16'h4000, 2'd3, 16'h4200, 1'b0},
        '{16'h3C00, 16'h0000, 2'd3, 16'h7E00, 1'b1},
        '{16'h7BFF, 16'h4000, 2'd2, 16'h7E00, 1'b1},
        '{16'h7C00, 16'h3C00, 2'd0, 16'h7E00, 1'b1},
        '{16'h3C00, 16'h3C00, 2'd1, 16'h0000, 1'b0},
        '{16'h0000, 16'h0000, 2'd2, 16'h0000, 1'b0},
        '{16'h0000, 16'h0000, 2'd3, 16'h7E00, 1'b1},
        '{16'h8400, 16'h0400, 2'd2, 16'h8000, 1'b0},
        '{16'h7BFF, 16'h7BFF, 2'd0, 16'h7E00, 1'b1},
        '{16'h0200, 16'h3C00, 2'd0, 16'h3C00, 1'b0},
        '{16'hC200, 16'h4000, 2'd0, 16'hBC00, 1'b0},
        '{16'h3C00, 16'h4200, 2'd3, 16'h3555, 1'b0},
        '{16'h5640, 16'h8000, 2'd2, 16'h8000, 1'b0}
    };

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   id_n  = 0;
    logic rdy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ready && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("result#%0d", mon_e.id), {16'd0, bus.result}, {16'd0, mon_e.res});
                check($sformatf("error#%0d", mon_e.id), {31'd0, bus.error}, {31'd0, mon_e.err});
                check($sformatf("latency#%0d", mon_e.id), cyc - mon_e.cyc, mon_e.lat);
            end
        end
        rdy_prev = bus.ready;
    end

    task automatic do_step(input logic [15:0] d);
        @(negedge clk);
        bus.data  = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data  = 16'hxxxx;
    endtask

    task automatic issue_exec(input logic [1:0] op, input logic [15:0] res, input logic err);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_q.push_back('{res: res, err: err, lat: (op == 2'd3) ? 15 : 3, cyc: cyc, id: id_n});
        id_n++;
    endtask

    task automatic exec_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input logic [15:0] res, input logic err);
        logic was_done;
        was_done = bus.ready;
        do_step(a);
        if (was_done) check("ready_fall", {31'd0, bus.ready}, 32'd0);
        do_step(b);
        do_step({14'($urandom), op});
        issue_exec(op, res, err);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, bus.ready}, 32'd1);
    endtask

    // Reference: exact signed integer sum on a common exponent grid, then truncate.
    function automatic logic [16:0] model_addsub(input logic [15:0] a, input logic [15:0] b,
                                                 input logic sub);
        int     ea, eb, emin, p, e;
        longint va, vb, s, mag;
        logic   sg;
        logic [9:0] fr;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 31 || eb == 31) return {1'b1, 16'h7E00};
        va   = (ea == 0) ? 64'd0 : longint'(1024 + int'(a[9:0]));
        vb   = (eb == 0) ? 64'd0 : longint'(1024 + int'(b[9:0]));
        emin = (ea < eb) ? ea : eb;
        va   = va << (ea - emin);
        vb   = vb << (eb - emin);
        if (a[15]) va = -va;
        if (b[15] ^ sub) vb = -vb;
        s = va + vb;
        if (s == 0) return 17'd0;
        sg  = (s < 0);
        mag = sg ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = p + emin - 10;
        if (p >= 10) fr = 10'((mag >> (p - 10)) & 64'd1023);
        else         fr = 10'((mag << (10 - p)) & 64'd1023);
        if (e < 1)  return {1'b0, sg, 15'd0};
        if (e > 30) return {1'b1, 16'h7E00};
        return {1'b0, sg, 5'(e), fr};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rsub;
        logic [16:0] m;
        int          ex;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.data  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < NDIR; k++) begin
            exec_op(dir[k].a, dir[k].b, dir[k].op, dir[k].res, dir[k].err);
            wait_done();
        end

        // A step while busy must not disturb the running divide.
        exec_op(16'h4600, 16'h4000, 2'd3, 16'h4200, 1'b0);
        do_step(16'h1234);
        wait_done();

        // start held high for several cycles is a single step.
        @(negedge clk);
        bus.data  = 16'h4000;
        bus.start = 1'b1;
        @(negedge clk);
        check("held_ready_fall", {31'd0, bus.ready}, 32'd0);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        bus.data  = 16'hxxxx;
        do_step(16'h4200);
        do_step(16'h0000);
        issue_exec(2'd0, 16'h4500, 1'b0);
        wait_done();

        // Reset in the middle of a divide.
        do_step(16'h4600);
        do_step(16'h4000);
        do_step(16'h0003);
        do_step(16'h0000);
        repeat (3) @(negedge clk);
        check("busy_not_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, bus.ready}, 32'd0);
        check("midrst_error", {31'd0, bus.error}, 32'd0);
        check("midrst_result", {16'd0, bus.result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exec_op(16'h4000, 16'h4200, 2'd2, 16'h4600, 1'b0);
        wait_done();

        for (int k = 0; k < 255; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 2 == 1) begin
                ex = int'(ra[14:10]) + int'($urandom_range(0, 4)) - 2;
                if (ex < 0)  ex = 0;
                if (ex > 31) ex = 31;
                rb[14:10] = 5'(ex);
            end
            rsub = 1'($urandom_range(0, 1));
            m = model_addsub(ra, rb, rsub);
            exec_op(ra, rb, {1'b0, rsub}, m[15:0], m[16]);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
